// File: rtl/parallel_hypervisor_cpu_ocimem_pkg.sv
// Shared types and constants for the OCI debug-memory / CPU arbiter.
package parallel_hypervisor_cpu_ocimem_pkg;
  localparam int RAM_AW_DEF  = 8;
  localparam int DW_DEF      = 32;

  // jdo field positions
  localparam int JDO_W       = 38;
  localparam int JDO_RD      = 35;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_CLR_ERR = 25;
  localparam int JDO_ADDR_LO = 26;

  typedef enum logic [1:0] {S_IDLE, S_CPU_RD, S_DBG_RD} state_e;
  typedef enum logic {GNT_CPU = 1'b0, GNT_DBG = 1'b1} gnt_e;

  typedef struct packed {
    logic pend;
    logic wr;
  } dbg_cmd_t;
endpackage

// File: rtl/parallel_hypervisor_cpu_ocimem_rr2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module parallel_hypervisor_cpu_ocimem_rr2
  import parallel_hypervisor_cpu_ocimem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_cpu,
  input  logic req_dbg,
  output logic gnt_cpu,
  output logic gnt_dbg
);
  gnt_e last_grant;

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (en) begin
      if (req_cpu && req_dbg) begin
        if (last_grant == GNT_CPU) gnt_dbg = 1'b1;
        else                       gnt_cpu = 1'b1;
      end else begin
        gnt_cpu = req_cpu;
        gnt_dbg = req_dbg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        last_grant <= GNT_CPU;
    else if (gnt_cpu) last_grant <= GNT_CPU;
    else if (gnt_dbg) last_grant <= GNT_DBG;
  end
endmodule

// File: rtl/parallel_hypervisor_cpu_ocimem_arbiter.sv
// Shares a single-port OCI RAM between the CPU slave port and the debug
// (jdo) command path; writes finish in the grant cycle, reads take one more.
module parallel_hypervisor_cpu_ocimem_arbiter
  import parallel_hypervisor_cpu_ocimem_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DW-1:0]     MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [RAM_AW-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DW-1:0]     cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [DW-1:0]     cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  input  logic [DW-1:0]     ram_rdata
);
  state_e            state, state_nxt;
  dbg_cmd_t          cmd;
  logic [RAM_AW-1:0] mon_areg;
  logic [DW-1:0]     rdata_q;
  logic              cpu_req, gnt_cpu, gnt_dbg, dbg_done, any_strobe;
  logic              unused_jdo;

  assign cpu_req       = cpu_read | cpu_write;
  assign any_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign monitor_ready = ~cmd.pend;
  assign cpu_readdata  = (state == S_CPU_RD) ? ram_rdata : rdata_q;
  assign unused_jdo    = ^{jdo[JDO_W-1:JDO_RD+1], jdo[JDO_DATA_LO-1:0]};

  // Grants only from IDLE; holding off during reset keeps ram_we quiet.
  parallel_hypervisor_cpu_ocimem_rr2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .en      ((state == S_IDLE) && !reset),
    .req_cpu (cpu_req),
    .req_dbg (cmd.pend),
    .gnt_cpu (gnt_cpu),
    .gnt_dbg (gnt_dbg)
  );

  always_comb begin
    state_nxt       = state;
    ram_addr        = mon_areg;
    ram_wdata       = MonDReg;
    ram_be          = 4'hF;
    ram_we          = 1'b0;
    dbg_done        = 1'b0;
    cpu_waitrequest = cpu_req;
    case (state)
      S_IDLE: begin
        if (gnt_cpu) begin
          ram_addr  = cpu_address;
          ram_wdata = cpu_writedata;
          ram_be    = cpu_byteenable;
          if (cpu_write) begin
            ram_we          = 1'b1;
            cpu_waitrequest = 1'b0;
          end else begin
            state_nxt = S_CPU_RD;
          end
        end else if (gnt_dbg) begin
          if (cmd.wr) begin
            ram_we   = 1'b1;
            dbg_done = 1'b1;
          end else begin
            state_nxt = S_DBG_RD;
          end
        end
      end
      S_CPU_RD: begin
        cpu_waitrequest = 1'b0;
        state_nxt       = S_IDLE;
      end
      S_DBG_RD: begin
        dbg_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mon_areg      <= '0;
      MonDReg       <= '0;
      rdata_q       <= '0;
      cmd           <= '0;
      monitor_error <= 1'b0;
    end else begin
      if (state == S_CPU_RD) rdata_q <= ram_rdata;
      if (state == S_DBG_RD) MonDReg <= ram_rdata;
      if (dbg_done) begin
        cmd.pend <= 1'b0;
        mon_areg <= mon_areg + 1'b1;
      end
      // New commands are only accepted while nothing is outstanding.
      if (!cmd.pend) begin
        if (take_action_ocimem_a) begin
          mon_areg <= jdo[JDO_ADDR_LO +: RAM_AW];
          if (jdo[JDO_RD])      cmd <= '{pend: 1'b1, wr: 1'b0};
          if (jdo[JDO_CLR_ERR]) monitor_error <= 1'b0;
        end else if (take_action_ocimem_b) begin
          MonDReg <= DW'(jdo[JDO_DATA_HI:JDO_DATA_LO]);
          cmd     <= '{pend: 1'b1, wr: 1'b1};
        end else if (take_no_action_ocimem_a) begin
          cmd <= '{pend: 1'b1, wr: 1'b0};
        end
      end
      // Overrun flag wins over a same-cycle clear.
      if ((any_strobe && cmd.pend) || (take_action_ocimem_a && take_action_ocimem_b))
        monitor_error <= 1'b1;
    end
  end
endmodule

// File: doc/parallel_hypervisor_cpu_ocimem_arbiter.md
PARALLEL_HYPERVISOR_CPU_OCIMEM_ARBITER -- requirements
Module: parallel_hypervisor_cpu_ocimem_arbiter

Interface
REQ-001 SHALL have parameters: RAM_AW, default 8, OCI RAM word-address width; DW, default 32, data width.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock, all logic on rising edge; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have debug-side ports: jdo  in  38  debug shift data (clk domain); take_action_ocimem_a  in  1  address/read command strobe; take_action_ocimem_b  in  1  write command strobe; take_no_action_ocimem_a  in  1  re-read strobe.
REQ-004 SHALL have debug-side outputs: MonDReg  out  DW  debug data register; monitor_ready  out  1  debug access idle; monitor_error  out  1  sticky command-overrun flag.
REQ-005 SHALL have CPU-side slave ports: cpu_address  in  RAM_AW; cpu_read  in  1; cpu_write  in  1; cpu_writedata  in  DW; cpu_byteenable  in  4; cpu_readdata  out  DW; cpu_waitrequest  out  1.
REQ-006 SHALL have RAM ports (single-port, 1-cycle read latency): ram_addr  out  RAM_AW; ram_wdata  out  DW; ram_be  out  4; ram_we  out  1; ram_rdata  in  DW.

Function
REQ-007 take_action_ocimem_a SHALL load MonAReg <= jdo[RAM_AW+25:26]; if jdo[35]=1 it SHALL post a debug read; if jdo[25]=1 it SHALL clear monitor_error.
REQ-008 take_action_ocimem_b SHALL load MonDReg <= jdo[34:3] and post a debug write (be=4'hF) to MonAReg.
REQ-009 take_no_action_ocimem_a SHALL post a debug read at MonAReg without changing it.
REQ-010 A posted debug command SHALL drop monitor_ready the next cycle; monitor_ready SHALL rise the cycle after the access completes.
REQ-011 A strobe arriving while a debug command is pending SHALL be dropped and set monitor_error; a+b in the same cycle SHALL execute a only and set monitor_error.
REQ-012 Each completed debug access SHALL increment MonAReg modulo 2^RAM_AW (255 -> 0).
REQ-013 FSM states IDLE, CPU_RD, DBG_RD; from IDLE, grant a requester; writes SHALL complete in the grant cycle (ram_we=1) and stay IDLE; reads SHALL drive ram_addr in the grant cycle and go to CPU_RD/DBG_RD, capture ram_rdata there, return to IDLE.
REQ-014 Arbitration SHALL be round-robin on last_grant when both CPU and debug request in IDLE; a lone requester SHALL be granted immediately; no new grant SHALL occur in CPU_RD/DBG_RD.
REQ-015 cpu_waitrequest SHALL be 1 whenever cpu_read|cpu_write is high except in the CPU write grant cycle and the CPU_RD cycle; cpu_readdata SHALL equal ram_rdata registered-through in CPU_RD and hold its value otherwise.
REQ-016 Debug read data SHALL load MonDReg in DBG_RD.
REQ-017 ram_we SHALL never assert outside a write grant cycle; CPU read+write asserted together SHALL be treated as write.
REQ-018 Worst-case CPU latency SHALL be 3 cycles (one debug read ahead of it).

Reset
REQ-019 On reset: state IDLE, MonAReg 0, MonDReg 0, pending 0, monitor_ready 1, monitor_error 0, cpu_readdata 0, ram_we 0, last_grant = CPU (debug wins first tie).
REQ-020 Reset asserted mid-read SHALL abort with no MonDReg/cpu_readdata update and no ram_we in the following cycle.

Structure
REQ-021 Package parallel_hypervisor_cpu_ocimem_pkg SHALL hold the state enum, RAM_AW/DW defaults, and jdo field positions (35 read, 34:3 data, 25 clear-error, 26+ address).
REQ-022 One sub-module, parallel_hypervisor_cpu_ocimem_rr2 (2-way round-robin arbiter with last_grant register), SHALL be instantiated.

Verification
REQ-023 take_action_ocimem_b jdo[34:3]=32'hDEADBEEF after _a addr 8'h10 -> ram_we=1 addr 10 data DEADBEEF; MonAReg=11; monitor_ready low 1 cycle, then high.
REQ-024 _a addr 8'hFF read, then take_no_action_ocimem_a -> MonDReg = RAM[FF] then RAM[00]; MonAReg wraps to 00 then 01.
REQ-025 CPU read addr 5 and debug read addr 6 same cycle after reset -> debug granted first, cpu_waitrequest low on cycle 3 with RAM[5].
REQ-026 Second strobe while pending -> dropped, monitor_error=1; _a with jdo[25]=1 -> monitor_error=0.
REQ-027 Continuous CPU writes plus debug writes -> grants alternate, each write lands once with correct byteenable.
REQ-028 Reset asserted in DBG_RD -> MonDReg stays 0, monitor_ready=1, state IDLE next cycle.
